spi_axis_poller: RTL and testbench
==================================

// Module: spi_axis_poller
// PURPOSE
//  Parametrised SPI-master poller for multi-axis sensors (ADXL345-class g-sensor).
//  Replaces the fixed 3-axis accelerometer SPI interface.
//  Autonomously issues burst reads of NUM_AXES x SAMPLE_W registers.
//  Presents each complete sample set on a valid/ready port to the NIOS-side or fabric consumer.
// PARAMETERS
//  NUM_AXES    3      axes per sample set (1..8)
//  SAMPLE_W    16     bits per axis; multiple of 8 (8..32)
//  CLK_DIV     25     clk cycles per SCLK half-period (>=2)
//  BASE_ADDR   6'h32  first data register address
//  GAP_CYCLES  1000   idle clk cycles with SS_n high between polls (>=1)
//  INIT_ADDR   6'h2D  init-write register (SPI_INIT_WRITE_EN only)
//  INIT_DATA   8'h08  init-write value (SPI_INIT_WRITE_EN only)
// PORTS
//  clk_clk        in   1                   system clock
//  reset_reset_n  in   1                   async active-low reset
//  enable         in   1                   1 = keep polling
//  spi_SCLK       out  1                   SPI clock, mode 3 (idle high)
//  spi_MOSI       out  1                   master out
//  spi_MISO       in   1                   master in
//  spi_SS_n       out  1                   chip select, active low
//  sample_data    out  NUM_AXES*SAMPLE_W   axis k at [k*SAMPLE_W +: SAMPLE_W]
//  sample_valid   out  1                   sample_data holds an unconsumed set
//  sample_ready   in   1                   consumer accepts when valid&ready
//  overrun        out  1                   sticky; set on overwrite of unconsumed set
//  overrun_clr    in   1                   clears overrun
//  busy           out  1                   1 whenever state != IDLE
// BEHAVIOUR
//  Reset values:
//  - Reset is asynchronous. SCLK=1, SS_n=1, MOSI=0, sample_data=0, sample_valid=0,
//    overrun=0, busy=0, state=IDLE.
//  - Takes effect immediately mid-transfer; partial data is discarded.
//  FSM: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> (enable ? CS_SETUP : IDLE).
//  - IDLE -> CS_SETUP when enable=1.
//  - CS_SETUP: SS_n low, one half-period.
//  - CS_HOLD: SCLK high, one half-period, then SS_n high.
//  - GAP: GAP_CYCLES clk cycles.
//  - Deasserting enable mid-transaction finishes the transaction and the gap, then IDLE.
//  Frame:
//  - Command byte {1'b1 (read), 1'b1 (multibyte), BASE_ADDR}, e.g. 8'hF2.
//  - Followed by NB = NUM_AXES*SAMPLE_W/8 read bytes; total 8*(1+NB) SCLK cycles.
//  - MSB first; MOSI changes on SCLK falling edge; MISO sampled on rising edge.
//  - MOSI = 0 during read bytes.
//  - Bytes are little-endian per axis: first byte -> axis0[7:0].
//  Completion (same clk edge that raises SS_n):
//  - sample_data updates, sample_valid <= 1.
//  - If valid=1 and not accepted that cycle, data is overwritten and overrun <= 1.
//  - valid&ready in the same cycle as completion: new set loads, valid stays 1, no overrun.
//  - valid&ready otherwise: valid <= 0 next edge.
//  - overrun_clr with a simultaneous overrun event: set wins.
//  SCLK half-period counter: 0..CLK_DIV-1, reloads at each SCLK edge; no drift across frame.
// CONFIGURATION
//  SPI_INIT_WRITE_EN defined:
//  - After reset, first enable runs one write frame {2'b00, INIT_ADDR, INIT_DATA}
//    (16 SCLK), states INIT_SETUP/INIT_SHIFT/INIT_HOLD, then GAP.
//  - No sample_valid for that frame.
//  - Runs once per reset only; also completes if enable drops mid-frame.
//  SPI_INIT_WRITE_EN undefined: no init states; the first frame is a read.
// TESTING (NUM_AXES=3, SAMPLE_W=16, CLK_DIV=2, GAP_CYCLES=4, macro undefined
// unless noted)
//  1 Reset, then enable=1, ready=1.
//    MISO model returns 34 12 78 56 BC 9A.
//    -> MOSI byte0 = F2, 56 SCLK cycles, SCLK period = 4 clk.
//    -> sample_data = 48'h9ABC_5678_1234, valid = 1.
//  2 ready=0 over two frames -> valid held, second set replaces first, overrun=1.
//    overrun_clr -> overrun=0 next cycle.
//  3 ready=1 in the completion cycle of frame 2 -> valid stays 1, overrun stays 0.
//  4 enable dropped at SCLK cycle 20 -> frame completes with 56 cycles.
//    -> busy=0 after the gap; no new SS_n low.
//  5 reset_reset_n low at SCLK cycle 30 -> SS_n=1, SCLK=1, valid=0 immediately, async.
//    Re-enable -> clean frame from the command byte.
//  6 SPI_INIT_WRITE_EN defined -> first frame MOSI = 2D 08, 16 SCLK, no valid.
//    Next frame is the read of test 1.

Source files
------------

// File: rtl/spi_axis_poller.sv
// SPI mode-3 master that polls a multi-axis sensor with burst reads and presents each
// sample set on a valid/ready port. Define SPI_INIT_WRITE_EN for a one-time init write.
module spi_axis_poller #(
  parameter int unsigned NUM_AXES   = 3,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned CLK_DIV    = 25,
  parameter logic [5:0]  BASE_ADDR  = 6'h32,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter logic [5:0]  INIT_ADDR  = 6'h2D,
  parameter logic [7:0]  INIT_DATA  = 8'h08
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         enable,
  output logic                         spi_SCLK,
  output logic                         spi_MOSI,
  input  logic                         spi_MISO,
  output logic                         spi_SS_n,
  output logic [NUM_AXES*SAMPLE_W-1:0] sample_data,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic                         busy
);

  localparam int unsigned DATA_W  = NUM_AXES * SAMPLE_W;
  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned FRAME_W = 8 * (NB + 1);
  localparam int unsigned DW      = $clog2(CLK_DIV);
  localparam int unsigned BW      = $clog2(FRAME_W + 1);
  localparam int unsigned GW      = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
`ifdef SPI_INIT_WRITE_EN
    StInitSetup,
    StInitShift,
    StInitHold,
`endif
    StGap
  } state_e;

  state_e              state_q;
  logic [DW-1:0]       div_q;
  logic [BW-1:0]       bit_q;
  logic [GW-1:0]       gap_q;
  logic [FRAME_W-1:0]  tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                sclk_q, ss_n_q, mosi_q, valid_q, overrun_q;
  logic [DATA_W-1:0]   data_q, data_new;

  logic                frame_init, init_pending, in_setup, in_shift, in_hold;
  state_e              st_setup, st_shift, st_hold;
  logic                half_done, gap_end, start;
  logic [BW-1:0]       frame_last;
  logic [FRAME_W-1:0]  tx_load;

`ifdef SPI_INIT_WRITE_EN
  logic init_done_q;

  assign frame_init   = (state_q == StInitSetup) || (state_q == StInitShift) ||
                        (state_q == StInitHold);
  assign init_pending = !init_done_q;
  assign st_setup     = init_pending ? StInitSetup : StCsSetup;
  assign st_shift     = frame_init ? StInitShift : StShift;
  assign st_hold      = frame_init ? StInitHold : StCsHold;
  assign in_setup     = (state_q == StCsSetup) || (state_q == StInitSetup);
  assign in_shift     = (state_q == StShift) || (state_q == StInitShift);
  assign in_hold      = (state_q == StCsHold) || (state_q == StInitHold);

  // Init write runs once per reset, regardless of enable during the frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      init_done_q <= 1'b0;
    end else if (in_hold && frame_init && half_done) begin
      init_done_q <= 1'b1;
    end
  end
`else
  assign frame_init   = 1'b0;
  assign init_pending = 1'b0;
  assign st_setup     = StCsSetup;
  assign st_shift     = StShift;
  assign st_hold      = StCsHold;
  assign in_setup     = (state_q == StCsSetup);
  assign in_shift     = (state_q == StShift);
  assign in_hold      = (state_q == StCsHold);
`endif

  assign half_done  = (div_q == DW'(CLK_DIV - 1));
  assign gap_end    = (gap_q == GW'(GAP_CYCLES - 1));
  assign start      = enable && ((state_q == StIdle) || ((state_q == StGap) && gap_end));
  assign frame_last = frame_init ? BW'(15) : BW'(FRAME_W - 1);
  assign tx_load    = init_pending ?
                      (FRAME_W'({2'b00, INIT_ADDR, INIT_DATA}) << (FRAME_W - 16)) :
                      (FRAME_W'({2'b11, BASE_ADDR}) << (FRAME_W - 8));

  // First received byte lands in axis0[7:0]; rx_q holds it in its top byte.
  always_comb begin
    data_new = '0;
    for (int j = 0; j < NB; j++) begin
      data_new[j*8 +: 8] = rx_q[(NB-1-j)*8 +: 8];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b1;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (valid_q && sample_ready) valid_q <= 1'b0;
      if (overrun_clr) overrun_q <= 1'b0;

      if (start) begin
        state_q <= st_setup;
        ss_n_q  <= 1'b0;
        div_q   <= '0;
        tx_q    <= tx_load;
      end else if (state_q == StGap) begin
        gap_q <= gap_q + 1'b1;
        if (gap_end) state_q <= StIdle;
      end else if (in_setup) begin
        div_q <= div_q + 1'b1;
        if (half_done) begin
          div_q   <= '0;
          sclk_q  <= 1'b0;
          mosi_q  <= tx_q[FRAME_W-1];
          tx_q    <= tx_q << 1;
          bit_q   <= '0;
          state_q <= st_shift;
        end
      end else if (in_shift) begin
        div_q <= div_q + 1'b1;
        if (half_done) begin
          div_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[DATA_W-2:0], spi_MISO};
            bit_q  <= bit_q + 1'b1;
            if (bit_q == frame_last) state_q <= st_hold;
          end else begin
            sclk_q <= 1'b0;
            mosi_q <= tx_q[FRAME_W-1];
            tx_q   <= tx_q << 1;
          end
        end
      end else if (in_hold) begin
        div_q <= div_q + 1'b1;
        if (half_done) begin
          div_q   <= '0;
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          gap_q   <= '0;
          state_q <= StGap;
          // Completion overrides the handshake clear and the overrun clear.
          if (!frame_init) begin
            data_q  <= data_new;
            valid_q <= 1'b1;
            if (valid_q && !sample_ready) overrun_q <= 1'b1;
          end
        end
      end
    end
  end

  assign spi_SCLK     = sclk_q;
  assign spi_SS_n     = ss_n_q;
  assign spi_MOSI     = mosi_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_spi_axis_poller.sv
// Randomized bench for spi_axis_poller: SPI slave model plus a behavioural model of the
// sample/valid/overrun port, compared every cycle. Honours SPI_INIT_WRITE_EN.
module tb_spi_axis_poller;

  localparam int unsigned NUM_AXES   = 3;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned NB         = NUM_AXES * SAMPLE_W / 8;
  localparam int unsigned DATA_W     = NUM_AXES * SAMPLE_W;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b1;
  logic              enable = 1'b0;
  logic              spi_SCLK, spi_MOSI, spi_SS_n;
  logic              spi_MISO = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic              overrun;
  logic              overrun_clr = 1'b0;
  logic              busy;

  spi_axis_poller #(
    .NUM_AXES  (NUM_AXES),
    .SAMPLE_W  (SAMPLE_W),
    .CLK_DIV   (CLK_DIV),
    .BASE_ADDR (6'h32),
    .GAP_CYCLES(GAP_CYCLES),
    .INIT_ADDR (6'h2D),
    .INIT_DATA (8'h08)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .enable       (enable),
    .spi_SCLK     (spi_SCLK),
    .spi_MOSI     (spi_MOSI),
    .spi_MISO     (spi_MISO),
    .spi_SS_n     (spi_SS_n),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .busy         (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI slave model ----------------
  bit          in_frame = 0, aborted = 1, this_init = 0, init_pend = 0, idle_seen = 1;
  int          rises, falls, ss_falls = 0, last_rise_cyc, ss_rise_cyc, k;
  logic [63:0] mosi_sr;
  logic [7:0]  rd_bytes [NB];
  logic [7:0]  fixed_q [$];
  bit          comp_pending = 0;
  logic [DATA_W-1:0] comp_data;

  always @(negedge spi_SS_n) begin
    ss_falls++;
    in_frame = 1; aborted = 0; rises = 0; falls = 0; mosi_sr = '0;
    if (!idle_seen) check("gap_len", 64'(cyc - ss_rise_cyc), GAP_CYCLES);
    this_init = init_pend; init_pend = 0;
    for (int j = 0; j < NB; j++) begin
      if (!this_init && fixed_q.size() > 0) rd_bytes[j] = fixed_q.pop_front();
      else rd_bytes[j] = 8'($urandom);
    end
  end

  // Slave shifts out on SCLK falling edges: 8 command-phase bits, then the read bytes MSB first.
  always @(negedge spi_SCLK) begin
    if (in_frame && !aborted) begin
      k = falls; falls++;
      if (k < 8 || k >= 8 * (NB + 1)) spi_MISO = 1'b0;
      else spi_MISO = rd_bytes[(k-8)/8][7-((k-8)%8)];
    end
  end

  always @(posedge spi_SCLK) begin
    if (in_frame && !aborted) begin
      if (rises > 0) check("sclk_period", 64'(cyc - last_rise_cyc), 2 * CLK_DIV);
      last_rise_cyc = cyc;
      rises++;
      mosi_sr = {mosi_sr[62:0], spi_MOSI};
    end
  end

  always @(posedge spi_SS_n) begin
    if (in_frame && !aborted) begin
      ss_rise_cyc = cyc; idle_seen = 0;
      if (this_init) begin
        check("init_bits", 64'(rises), 16);
        check("init_mosi", mosi_sr[15:0], 16'h2D08);
      end else begin
        check("frame_bits", 64'(rises), 56);
        check("cmd_byte", mosi_sr[55:48], 8'hF2);
        check("read_mosi_zero", mosi_sr[47:0], 48'h0);
        for (int j = 0; j < NB; j++) comp_data[j*8 +: 8] = rd_bytes[j];
        comp_pending = 1;
      end
    end
    in_frame = 0;
  end

  // ---------------- output-port model ----------------
  logic [DATA_W-1:0] exp_data = '0;
  bit exp_valid = 0, exp_ovr = 0, m_rdy, m_clr, m_acc, m_set;
  int comp_count = 0;

  always @(posedge clk_clk) begin
    m_rdy = sample_ready; m_clr = overrun_clr;
    #1;
    if (!reset_reset_n) begin
      exp_valid = 0; exp_ovr = 0; exp_data = '0; comp_pending = 0;
    end else begin
      m_acc = exp_valid && m_rdy;
      m_set = 0;
      if (comp_pending) begin
        comp_pending = 0; comp_count++;
        if (exp_valid && !m_acc) m_set = 1;
        exp_valid = 1; exp_data = comp_data;
      end else if (m_acc) begin
        exp_valid = 0;
      end
      if (m_set) exp_ovr = 1;
      else if (m_clr) exp_ovr = 0;
    end
  end

  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      check("valid", sample_valid, exp_valid);
      check("overrun", overrun, exp_ovr);
      check("data", sample_data, exp_data);
      if (!busy) idle_seen = 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    aborted = 1;
    reset_reset_n = 1'b0;
    #1;
    check("rst_ss_n", spi_SS_n, 1'b1);
    check("rst_sclk", spi_SCLK, 1'b1);
    check("rst_mosi", spi_MOSI, 1'b0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", sample_data, 48'h0);
    idle_seen = 1;
`ifdef SPI_INIT_WRITE_EN
    init_pend = 1;
`endif
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic wait_comp(input int target, input string name);
    int b = 0;
    while (comp_count < target && b < 3000) begin @(negedge clk_clk); b++; end
    if (comp_count < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: completions %0d, required %0d before timeout", name, comp_count, target);
    end
  endtask

  task automatic wait_rise(input int n, input string name);
    int b = 0;
    while (!(in_frame && rises == n) && b < 3000) begin @(negedge clk_clk); b++; end
    if (b >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: SCLK rise %0d not reached, got %0d", name, n, rises);
    end
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while (busy && b < 3000) begin @(negedge clk_clk); b++; end
    check(name, busy, 1'b0);
  endtask

  task automatic rand_run(input int n, input string name);
    int target = comp_count + n;
    int b = 0;
    while (comp_count < target && b < n * 1500) begin
      @(negedge clk_clk);
      sample_ready = 1'($urandom % 2);
      overrun_clr  = ($urandom % 6 == 0);
      b++;
    end
    overrun_clr = 1'b0;
    sample_ready = 1'b1;
    if (comp_count < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: completions %0d, required %0d before timeout", name, comp_count, target);
    end
  endtask

  // ---------------- stimulus ----------------
  int base, f;
  initial begin
    #2 do_reset();

    // Fixed first read frame (after the init write when that feature is built in).
    fixed_q = {8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    @(negedge clk_clk);
    sample_ready = 1'b1; enable = 1'b1;
    wait_comp(1, "t1_complete");
    check("t1_data", sample_data, 48'h9ABC_5678_1234);
    check("t1_valid", sample_valid, 1'b1);

    // Consumer stalled over two frames: newest set wins, overrun sticks.
    sample_ready = 1'b0;
    base = comp_count;
    wait_comp(base + 2, "t2_complete");
    check("t2_valid", sample_valid, 1'b1);
    check("t2_overrun", overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk_clk);
    overrun_clr = 1'b0;
    check("t2_overrun_clr", overrun, 1'b0);

    // Accept exactly on the completion edge: valid stays high, no overrun.
    wait_rise(56, "t3_rise");
    repeat (CLK_DIV - 1) @(negedge clk_clk);
    sample_ready = 1'b1;
    @(negedge clk_clk);
    sample_ready = 1'b0;
    check("t3_ss_high", spi_SS_n, 1'b1);
    check("t3_valid", sample_valid, 1'b1);
    check("t3_overrun", overrun, 1'b0);

    rand_run(3, "rand_a");

    // Enable dropped mid-frame: frame and gap finish, then idle with no new frame.
    wait_rise(20, "t4_rise");
    enable = 1'b0;
    check("t4_busy_mid", busy, 1'b1);
    wait_idle("t4_idle");
    f = ss_falls;
    repeat (60) @(negedge clk_clk);
    check("t4_no_new_frame", 64'(ss_falls), 64'(f));
    check("t4_still_idle", busy, 1'b0);

    // Asynchronous reset mid-frame, then a clean restart.
    enable = 1'b1;
    wait_rise(30, "t5_rise");
    #2 do_reset();
    base = comp_count;
    wait_comp(base + 1, "t5_restart");
    check("t5_valid", sample_valid, 1'b1);

    rand_run(4, "rand_b");

    enable = 1'b0;
    wait_idle("final_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
